// File: rtl/sdft_pkg.sv
// Shared definitions for the sliding-DFT sequencer: FSM encoding, core read
// latency and default widths.
package sdft_pkg;

    localparam int SDFT_DATA_W     = 8;
    localparam int SDFT_FREQ_W     = 16;
    localparam int SDFT_LIMIT_BINS = 32;
    localparam int SDFT_DECIM      = 4;

    // Cycles from an address at the core to its magnitude on bin_out.
    localparam int SDFT_RD_LAT     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } sdft_state_e;

endpackage

// File: rtl/sdft_tag_pipe.sv
// Valid+tag shift register that follows each issued bin address through the
// core read latency, so the returning magnitude can be labelled with its bin.
module sdft_tag_pipe
    import sdft_pkg::*;
#(
    parameter int TAG_W  = 5,
    parameter int STAGES = SDFT_RD_LAT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_vld,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    output logic [TAG_W-1:0] out_tag,
    output logic             in_flight
);

    logic [STAGES:1]            vld_pipe_q, vld_pipe_d;
    logic [STAGES:1][TAG_W-1:0] tag_pipe_q, tag_pipe_d;
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][TAG_W-1:0] tag_pipe;

    always_comb begin
        vld_pipe   = {vld_pipe_q, in_vld};
        tag_pipe   = {tag_pipe_q, in_tag};
        vld_pipe_d = vld_pipe[STAGES-1:0];
        tag_pipe_d = tag_pipe[STAGES-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            tag_pipe_q <= tag_pipe_d;
        end
    end

    assign out_vld   = vld_pipe_q[STAGES];
    assign out_tag   = tag_pipe_q[STAGES];
    // Tags that will still be waiting on the core after this cycle's output.
    assign in_flight = |vld_pipe[STAGES-1:0];

endmodule

// File: rtl/sdft_sequencer.sv
// Shares the sliding-DFT core between the ADC sample stream (priority) and
// waterfall line readout. Optional input decimation: SDFT_SEQ_DECIM_EN.
module sdft_sequencer
    import sdft_pkg::*;
#(
    parameter int DATA_W     = SDFT_DATA_W,
    parameter int FREQ_W     = SDFT_FREQ_W,
    parameter int LIMIT_BINS = SDFT_LIMIT_BINS,
    parameter int DECIM      = SDFT_DECIM,
    localparam int BIN_ADDR_W = $clog2(LIMIT_BINS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    input  logic                  line_req,
    input  logic                  sdft_ready,
    input  logic [FREQ_W-1:0]     sdft_bin_out,
    output logic                  sdft_start,
    output logic                  sdft_read,
    output logic [BIN_ADDR_W-1:0] sdft_bin_addr,
    output logic [DATA_W-1:0]     sdft_sample,
    output logic                  line_valid,
    output logic [BIN_ADDR_W-1:0] line_bin,
    output logic [FREQ_W-1:0]     line_data,
    output logic                  line_last,
    output logic                  overrun
);

    localparam logic [BIN_ADDR_W-1:0] LAST_BIN = BIN_ADDR_W'(LIMIT_BINS - 1);

    sdft_state_e           state_q, state_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_W-1:0]     buf_data_q, buf_data_d;
    logic [DATA_W-1:0]     hold_q, hold_d;
    logic                  pending_q, pending_d;
    logic [BIN_ADDR_W-1:0] next_bin_q, next_bin_d;
    logic                  overrun_q, overrun_d;
    logic                  busy_low_q, busy_low_d;

    logic                  s_acc;
    logic                  start;
    logic                  read;
    logic                  issue;
    logic                  tag_vld;
    logic [BIN_ADDR_W-1:0] tag;
    logic                  in_flight;
    logic                  last_beat;

`ifdef SDFT_SEQ_DECIM_EN
    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;

    always_comb begin
        dec_cnt_d = dec_cnt_q;
        if (s_valid) begin
            dec_cnt_d = (dec_cnt_q == DEC_W'(DECIM - 1)) ? '0 : dec_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dec_cnt_q <= '0;
        else          dec_cnt_q <= dec_cnt_d;
    end

    // Strobes 1, DECIM+1, ... pass; the rest never touch the buffer.
    assign s_acc = s_valid && (dec_cnt_q == '0);
`else
    assign s_acc = s_valid;
`endif

    assign last_beat = tag_vld && (tag == LAST_BIN);

    always_comb begin
        state_d    = state_q;
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        hold_d     = hold_q;
        pending_d  = pending_q;
        next_bin_d = next_bin_q;
        overrun_d  = overrun_q;
        busy_low_d = busy_low_q;
        read       = 1'b0;
        issue      = 1'b0;
        start      = (state_q == ST_IDLE) && buf_full_q && sdft_ready;

        // Single-entry sample buffer; a strobe that finds it full is lost.
        if (start) buf_full_d = 1'b0;
        if (s_acc) begin
            if (buf_full_q) begin
                overrun_d = 1'b1;
            end else begin
                buf_full_d = 1'b1;
                buf_data_d = s_data;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hold_d     = buf_data_q;
                    busy_low_d = 1'b0;
                    state_d    = ST_BUSY;
                end else if (pending_q && sdft_ready) begin
                    read    = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_BUSY: begin
                // Core must be seen busy before its ready counts as done.
                if (!sdft_ready) begin
                    busy_low_d = 1'b1;
                end else if (busy_low_q) begin
                    busy_low_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_READ: begin
                read       = 1'b1;
                issue      = 1'b1;
                next_bin_d = next_bin_q + 1'b1;
                if (next_bin_q == LAST_BIN || buf_full_d) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!in_flight && sdft_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Only reachable with no line pending, so never races the bin increment.
        if (last_beat) begin
            pending_d = 1'b0;
        end else if (line_req && !pending_q) begin
            pending_d  = 1'b1;
            next_bin_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            hold_q     <= '0;
            pending_q  <= 1'b0;
            next_bin_q <= '0;
            overrun_q  <= 1'b0;
            busy_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            next_bin_q <= next_bin_d;
            overrun_q  <= overrun_d;
            busy_low_q <= busy_low_d;
        end
    end

    sdft_tag_pipe #(
        .TAG_W  (BIN_ADDR_W),
        .STAGES (SDFT_RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_vld    (issue),
        .in_tag    (next_bin_q),
        .out_vld   (tag_vld),
        .out_tag   (tag),
        .in_flight (in_flight)
    );

    // Sample is shown straight from the buffer on the start cycle, then held.
    assign sdft_sample   = start ? buf_data_q : hold_q;
    assign sdft_start    = start;
    assign sdft_read     = read;
    assign sdft_bin_addr = next_bin_q;

    assign line_valid = tag_vld;
    assign line_bin   = tag_vld ? tag : '0;
    assign line_data  = tag_vld ? sdft_bin_out : '0;
    assign line_last  = last_beat;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sdft_sequencer.sv
// Directed bench for sdft_sequencer with a small behavioural sliding-DFT core.
module tb_sdft_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        line_req = 1'b0;
    logic        sdft_ready;
    logic [15:0] sdft_bin_out;
    logic        sdft_start, sdft_read;
    logic [4:0]  sdft_bin_addr;
    logic [7:0]  sdft_sample;
    logic        line_valid;
    logic [4:0]  line_bin;
    logic [15:0] line_data;
    logic        line_last;
    logic        overrun;

    sdft_sequencer #(
        .DATA_W (8), .FREQ_W (16), .LIMIT_BINS (32), .DECIM (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .line_req      (line_req),
        .sdft_ready    (sdft_ready),
        .sdft_bin_out  (sdft_bin_out),
        .sdft_start    (sdft_start),
        .sdft_read     (sdft_read),
        .sdft_bin_addr (sdft_bin_addr),
        .sdft_sample   (sdft_sample),
        .line_valid    (line_valid),
        .line_bin      (line_bin),
        .line_data     (line_data),
        .line_last     (line_last),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: update busy for 5 cycles, ready low one cycle behind read,
    // magnitude two cycles after its address.
    int         busy_cnt = 0;
    logic       rd_d1 = 1'b0;
    logic [4:0] a1 = '0, a2 = '0;

    function automatic logic [15:0] fmag(input int b);
        return 16'h1000 + 16'(b * 37);
    endfunction

    always @(posedge clk) begin
        rd_d1 <= sdft_read;
        a1    <= sdft_bin_addr;
        a2    <= a1;
        if (sdft_start)        busy_cnt <= 5;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign sdft_ready   = (busy_cnt == 0) && !rd_d1;
    assign sdft_bin_out = fmag(int'(a2));

    // Event recorder.
    int         st_cyc[$];
    logic [7:0] st_smp[$];
    int         rd_first[$];
    int         iss[$];
    int         iss_cyc[$];
    int         bt_bin[$];
    logic [15:0] bt_dat[$];
    bit         bt_last[$];
    int         bt_cyc[$];
    int         n_last = 0;
    int         stab_err = 0;
    bit         holding = 1'b0;
    logic [7:0] hold_val = '0;
    bit         rd_prev = 1'b0;

    always @(negedge clk) begin
        if (sdft_start) begin
            st_cyc.push_back(cyc);
            st_smp.push_back(sdft_sample);
            holding  = 1'b1;
            hold_val = sdft_sample;
        end else if (holding) begin
            if (sdft_ready) holding = 1'b0;
            else if (sdft_sample !== hold_val) stab_err++;
        end
        if (sdft_read && !rd_prev) begin
            rd_first.push_back(cyc);
        end else if (sdft_read) begin
            iss.push_back(int'(sdft_bin_addr));
            iss_cyc.push_back(cyc);
        end
        rd_prev = sdft_read;
        if (line_valid) begin
            bt_bin.push_back(int'(line_bin));
            bt_dat.push_back(line_data);
            bt_last.push_back(line_last);
            bt_cyc.push_back(cyc);
            if (line_last) n_last++;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        st_cyc.delete(); st_smp.delete(); rd_first.delete();
        iss.delete(); iss_cyc.delete();
        bt_bin.delete(); bt_dat.delete(); bt_last.delete(); bt_cyc.delete();
        n_last = 0; stab_err = 0; holding = 1'b0;
    endtask

    task automatic pulse_s(input logic [7:0] d);
        s_data  = d;
        s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
    endtask

    task automatic pulse_line();
        line_req = 1'b1;
        tick(1);
        line_req = 1'b0;
    endtask

    task automatic wait_lines(input string tag, input int n, input int lim);
        int w;
        w = 0;
        while (n_last < n && w < lim) begin
            tick(1);
            w++;
        end
        chk(tag, 32'(n_last >= n), 32'd1);
    endtask

    // Full-line content check: bins 0..31 once each, ascending, with core data.
    task automatic chk_line(input string tag);
        int bad_bin, bad_dat, bad_last;
        bad_bin = 0; bad_dat = 0; bad_last = 0;
        chk({tag, "_nbeat"}, 32'(bt_bin.size()), 32'd32);
        foreach (bt_bin[i]) begin
            if (bt_bin[i] != i) bad_bin++;
            if (bt_dat[i] !== fmag(i)) bad_dat++;
            if (bt_last[i] != (i == 31)) bad_last++;
        end
        chk({tag, "_bins"}, 32'(bad_bin), 32'd0);
        chk({tag, "_data"}, 32'(bad_dat), 32'd0);
        chk({tag, "_last"}, 32'(bad_last), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, expected finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        int k, w, bad;

        // Reset state
        tick(3);
        chk("rst_ctl",  32'({sdft_start, sdft_read, sdft_bin_addr}), 32'd0);
        chk("rst_smp",  32'(sdft_sample), 32'd0);
        chk("rst_line", 32'({line_valid, line_bin, line_last}), 32'd0);
        chk("rst_data", 32'(line_data), 32'd0);
        chk("rst_ovr",  32'(overrun), 32'd0);
        reset_n = 1'b1;
        tick(4);

        // T1: single sample
        clr();
        k = cyc;
        pulse_s(8'h40);
        tick(20);
        chk("t1_nstart", 32'(st_cyc.size()), 32'd1);
        chk("t1_lat",    32'(st_cyc.size() > 0 ? st_cyc[0] - k : -1), 32'd1);
        chk("t1_sample", 32'(st_smp.size() > 0 ? st_smp[0] : 8'h00), 32'h40);
        chk("t1_hold",   32'(stab_err), 32'd0);
        chk("t1_nobeat", 32'(bt_bin.size() + rd_first.size()), 32'd0);

        // T2: full line, repeated line_req mid-line is ignored
        clr();
        k = cyc;
        pulse_line();
        w = 0;
        while (!(sdft_read && sdft_bin_addr == 5'd5) && w < 100) begin
            tick(1);
            w++;
        end
        pulse_line();
        wait_lines("t2_done", 1, 200);
        tick(10);
        chk("t2_t0",    32'(rd_first.size() > 0 ? rd_first[0] - k : -1), 32'd1);
        chk("t2_nrun",  32'(rd_first.size()), 32'd1);
        chk_line("t2");
        chk("t2_lastcyc", 32'((bt_cyc.size() == 32 && rd_first.size() > 0) ?
                              bt_cyc[31] - rd_first[0] : -1), 32'd34);
        bad = 0;
        if (iss_cyc.size() != bt_cyc.size()) bad++;
        else foreach (bt_cyc[i]) if (bt_cyc[i] - iss_cyc[i] != 2) bad++;
        chk("t2_latency", 32'(bad), 32'd0);
        chk("t2_nostart", 32'(st_cyc.size()), 32'd0);

        // T3: sample arrives while bin 10 is issued
        clr();
        pulse_line();
        w = 0;
        while (!(sdft_read && sdft_bin_addr == 5'd10) && w < 100) begin
            tick(1);
            w++;
        end
        chk("t3_reach10", 32'(w < 100), 32'd1);
        pulse_s(8'h5A);
        wait_lines("t3_done", 1, 300);
        tick(10);
        chk_line("t3");
        bad = 0;
        if (iss.size() != 32) bad++;
        else foreach (iss[i]) if (iss[i] != i) bad++;
        chk("t3_issue",  32'(bad), 32'd0);
        chk("t3_nrun",   32'(rd_first.size()), 32'd2);
        chk("t3_nstart", 32'(st_cyc.size()), 32'd1);
        chk("t3_sample", 32'(st_smp.size() > 0 ? st_smp[0] : 8'h00), 32'h5A);
        chk("t3_order",  32'((st_cyc.size() > 0 && rd_first.size() > 1 && iss_cyc.size() > 11) ?
                             (st_cyc[0] > iss_cyc[10] && st_cyc[0] < rd_first[1] &&
                              iss_cyc[11] > rd_first[1]) : 0), 32'd1);

        // T4: two strobes during an update
        clr();
        chk("t4_ovr0", 32'(overrun), 32'd0);
        pulse_s(8'h11);
        tick(1);
        pulse_s(8'h22);
        pulse_s(8'h33);
        tick(30);
        chk("t4_ovr",     32'(overrun), 32'd1);
        chk("t4_nstart",  32'(st_cyc.size()), 32'd2);
        chk("t4_smp0",    32'(st_smp.size() > 0 ? st_smp[0] : 8'h00), 32'h11);
        chk("t4_smp1",    32'(st_smp.size() > 1 ? st_smp[1] : 8'h00), 32'h22);
        chk("t4_hold",    32'(stab_err), 32'd0);
        tick(20);
        chk("t4_sticky",  32'(overrun), 32'd1);

        // T5: sample and line request together
        clr();
        s_data   = 8'h77;
        s_valid  = 1'b1;
        line_req = 1'b1;
        tick(1);
        s_valid  = 1'b0;
        line_req = 1'b0;
        wait_lines("t5_done", 1, 300);
        tick(10);
        chk("t5_nstart", 32'(st_cyc.size()), 32'd1);
        chk("t5_sample", 32'(st_smp.size() > 0 ? st_smp[0] : 8'h00), 32'h77);
        chk("t5_first",  32'((st_cyc.size() > 0 && rd_first.size() > 0) ?
                             (st_cyc[0] < rd_first[0]) : 0), 32'd1);
        chk_line("t5");

        // T6: reset during a readout
        clr();
        pulse_line();
        tick(8);
        reset_n = 1'b0;
        tick(1);
        chk("t6_rst_ovr",  32'(overrun), 32'd0);
        chk("t6_rst_ctl",  32'({sdft_start, sdft_read, sdft_bin_addr}), 32'd0);
        chk("t6_rst_line", 32'({line_valid, line_bin, line_last}), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        clr();
        tick(20);
        chk("t6_abandon", 32'(bt_bin.size() + rd_first.size()), 32'd0);
        pulse_line();
        wait_lines("t6_done", 1, 200);
        tick(10);
        chk_line("t6");

`ifdef SDFT_SEQ_DECIM_EN
        // T7: decimation passes strobes 1 and 5 of 8
        clr();
        for (int i = 1; i <= 8; i++) begin
            pulse_s(8'(i));
            tick(1);
        end
        tick(30);
        chk("t7_nstart", 32'(st_cyc.size()), 32'd2);
        chk("t7_smp0",   32'(st_smp.size() > 0 ? st_smp[0] : 8'h00), 32'd1);
        chk("t7_smp1",   32'(st_smp.size() > 1 ? st_smp[1] : 8'h00), 32'd5);
        chk("t7_ovr",    32'(overrun), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
